// File: rtl/gray_count_cfg.sv
// gray_count_cfg
// Parametrised Gray-code counter for the feedback path. The count is held as a
// binary register and re-encoded to Gray on every update, so both views are
// registered and have no combinational path from the inputs. Gray-coded counts
// are safe to sample from slower or asynchronous logic because every count
// step changes exactly one bit.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   SATURATE  0: wrap modulo 2^WIDTH, 1: hold at all-ones (up) / zero (down)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous reset, active low
//   enable      count one step this cycle
//   up_dn       1: count up, 0: count down
//   clear       synchronous clear to zero (highest priority)
//   load        synchronous load of load_gray
//   load_gray   Gray-coded load value
//   cmp_gray    Gray-coded compare value
//   gray_count  registered Gray count
//   bin_count   registered binary equivalent of gray_count
//   wrap        one-cycle pulse after a wrapping count step
//   sat         count is pinned at its end value for the current up_dn
//   match       gray_count equals the cmp_gray sampled on the same edge

module gray_count_cfg #(
    parameter int WIDTH    = 17,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    input  logic [WIDTH-1:0] cmp_gray,
    output logic [WIDTH-1:0] gray_count,
    output logic [WIDTH-1:0] bin_count,
    output logic             wrap,
    output logic             sat,
    output logic             match
);

    localparam logic [WIDTH-1:0] COUNT_MAX  = '1;
    localparam logic [WIDTH-1:0] COUNT_ZERO = '0;
    localparam logic [WIDTH-1:0] COUNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;
    logic             sat_next;

    // Each binary bit is the XOR of all Gray bits at and above it; the running
    // accumulator walks from the MSB down.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] r;
        logic             acc;
        r   = '0;
        acc = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            r[i] = acc;
        end
        return r;
    endfunction

    assign load_bin = gray_to_bin(load_gray);

    // Next-state selection: clear beats load beats a count step. At the end
    // of the range the count either wraps (raising wrap) or stays put when
    // saturating.
    always_comb begin
        b_next    = b;
        wrap_next = 1'b0;
        if (clear) begin
            b_next = COUNT_ZERO;
        end else if (load) begin
            b_next = load_bin;
        end else if (enable) begin
            if (up_dn) begin
                if (b == COUNT_MAX) begin
                    if (!SATURATE) begin
                        b_next    = COUNT_ZERO;
                        wrap_next = 1'b1;
                    end
                end else begin
                    b_next = b + COUNT_ONE;
                end
            end else begin
                if (b == COUNT_ZERO) begin
                    if (!SATURATE) begin
                        b_next    = COUNT_MAX;
                        wrap_next = 1'b1;
                    end
                end else begin
                    b_next = b - COUNT_ONE;
                end
            end
        end
    end

    // The saturation flag looks at the value being stored together with the
    // direction requested now, so reversing direction drops it immediately.
    always_comb begin
        sat_next  = SATURATE && ((up_dn && (b_next == COUNT_MAX)) ||
                                 (!up_dn && (b_next == COUNT_ZERO)));
        gray_next = b_next ^ (b_next >> 1);
    end

    // All outputs are registered from the next-state values so that gray_count,
    // bin_count and the flags always refer to the same count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b          <= COUNT_ZERO;
            gray_count <= COUNT_ZERO;
            wrap       <= 1'b0;
            sat        <= 1'b0;
            match      <= 1'b0;
        end else begin
            b          <= b_next;
            gray_count <= gray_next;
            wrap       <= wrap_next;
            sat        <= sat_next;
            match      <= (gray_next == cmp_gray);
        end
    end

    assign bin_count = b;

endmodule
